// File: rtl/spi_master_engine.sv
// ---------------------------------------------------------------------------
// spi_master_engine
//
// Purpose:
//   SPI master transfer engine. A 0->1 edge on start_op (seen while idle)
//   latches tx_data and the control fields into shadow registers. The engine
//   then runs one DATA_W-bit full-duplex transfer on sclk/mosi/miso/ss_n.
//   busy reports activity. done pulses for one cycle at completion.
//   rx_data returns the received word when ctrl_rd was set at start.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-low reset
//   tx_data        in   word to transmit (latched at start)
//   ctrl_cpol      in   sclk idle level
//   ctrl_cpha      in   0: sample on leading edge, 1: sample on trailing edge
//   ctrl_order     in   0: MSB first, 1: LSB first (tx and rx)
//   ctrl_slave_en  in   bit i=1 drives ss_n[i] low during the transfer
//   ctrl_rd        in   1: capture received word into rx_data at the end
//   ctrl_scks      in   sclk half-period H = 2^ctrl_scks clk cycles
//   start_op       in   level; a transfer starts on its 0->1 edge
//   miso           in   serial data from slave (synchronous to clk)
//   sclk           out  serial clock
//   mosi           out  serial data to slave
//   ss_n           out  active-low slave selects
//   rx_data        out  last received word
//   busy           out  1 whenever the engine is not idle
//   done           out  1-cycle completion pulse
//
// Handshake: start_op is a level; only its rising edge seen in IDLE starts a
//   transfer. Rises while busy are dropped, not queued. busy rises the cycle
//   after the edge is seen and falls after the done pulse.
// ---------------------------------------------------------------------------
module spi_master_engine #(
    parameter int DATA_W = 32,
    parameter int NUM_SS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              ctrl_cpol,
    input  logic              ctrl_cpha,
    input  logic              ctrl_order,
    input  logic [NUM_SS-1:0] ctrl_slave_en,
    input  logic              ctrl_rd,
    input  logic [1:0]        ctrl_scks,
    input  logic              start_op,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done
);

    // Half-period index counter covers 2*DATA_W half-periods.
    localparam int HP_W = $clog2(2 * DATA_W);
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(2 * DATA_W - 1);
    localparam logic [HP_W-1:0] HP_ONE  = HP_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              start_prev_q, start_prev_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              order_q, order_d;
    logic [NUM_SS-1:0] slave_en_q, slave_en_d;
    logic              rd_q, rd_d;
    logic [1:0]        scks_q, scks_d;
    logic [2:0]        tmr_q, tmr_d;
    logic [HP_W-1:0]   hp_q, hp_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    logic start_rise;
    logic tmr_end;
    logic lead_edge;
    logic trail_edge;
    logic sample_now;
    logic drive_now;

    // Reload value of the per-half-period cycle timer (H-1).
    function automatic logic [2:0] half_minus_one(input logic [1:0] scks);
        case (scks)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            // A level already high at reset release must not look like an edge.
            start_prev_q <= 1'b1;
            shift_q      <= '0;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            order_q      <= 1'b0;
            slave_en_q   <= '0;
            rd_q         <= 1'b0;
            scks_q       <= 2'd0;
            tmr_q        <= 3'd0;
            hp_q         <= '0;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            rx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            shift_q      <= shift_d;
            cpol_q       <= cpol_d;
            cpha_q       <= cpha_d;
            order_q      <= order_d;
            slave_en_q   <= slave_en_d;
            rd_q         <= rd_d;
            scks_q       <= scks_d;
            tmr_q        <= tmr_d;
            hp_q         <= hp_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            rx_data_q    <= rx_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_prev_d = start_op;
        shift_d      = shift_q;
        cpol_d       = cpol_q;
        cpha_d       = cpha_q;
        order_d      = order_q;
        slave_en_d   = slave_en_q;
        rd_d         = rd_q;
        scks_d       = scks_q;
        tmr_d        = tmr_q;
        hp_d         = hp_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;
        rx_data_d    = rx_data_q;

        start_rise = start_op & ~start_prev_q;
        tmr_end    = (tmr_q == 3'd0);

        // Half-period k = HP_LAST - hp_q. Leaving SETUP opens half-period 0
        // (leading edge of bit 0). Inside SHIFT, the boundary that opens an
        // even half-period is a leading edge and an odd one a trailing edge.
        // The boundary at hp_q == 0 ends SHIFT with no sclk edge.
        lead_edge  = tmr_end &&
                     ((state_q == ST_SETUP) ||
                      ((state_q == ST_SHIFT) && (hp_q != '0) && !hp_q[0]));
        trail_edge = tmr_end && (state_q == ST_SHIFT) && hp_q[0];

        sample_now = (lead_edge && !cpha_q) || (trail_edge && cpha_q);
        // With cpha=0 the trailing edge of the last bit drives nothing, so
        // mosi keeps the last bit through HOLD.
        drive_now  = (lead_edge && cpha_q) ||
                     (trail_edge && !cpha_q && (hp_q != HP_ONE));

        case (state_q)
            ST_IDLE: begin
                sclk_d = ctrl_cpol;
                if (start_rise) begin
                    shift_d    = tx_data;
                    cpol_d     = ctrl_cpol;
                    cpha_d     = ctrl_cpha;
                    order_d    = ctrl_order;
                    slave_en_d = ctrl_slave_en;
                    rd_d       = ctrl_rd;
                    scks_d     = ctrl_scks;
                    tmr_d      = half_minus_one(ctrl_scks);
                    hp_d       = HP_LAST;
                    // cpha=0 needs the first bit on the line before the
                    // leading edge samples it.
                    if (!ctrl_cpha) begin
                        mosi_d = ctrl_order ? tx_data[0] : tx_data[DATA_W-1];
                    end
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_end) begin
                    tmr_d   = half_minus_one(scks_q);
                    state_d = ST_SHIFT;
                end else begin
                    tmr_d = tmr_q - 3'd1;
                end
            end
            ST_SHIFT: begin
                if (tmr_end) begin
                    tmr_d = half_minus_one(scks_q);
                    if (hp_q == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        hp_d = hp_q - HP_ONE;
                    end
                end else begin
                    tmr_d = tmr_q - 3'd1;
                end
            end
            ST_HOLD: begin
                sclk_d = cpol_q;
                if (tmr_end) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q - 3'd1;
                end
            end
            ST_DONE: begin
                if (rd_q) begin
                    rx_data_d = shift_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (lead_edge || trail_edge) begin
            sclk_d = ~sclk_q;
        end

        // One register serves both directions: tx bits leave at one end while
        // rx bits enter at the other, so after DATA_W samples it holds the
        // received word with the same significance as tx_data.
        if (drive_now) begin
            mosi_d = order_q ? shift_q[0] : shift_q[DATA_W-1];
        end
        if (sample_now) begin
            shift_d = order_q ? {miso, shift_q[DATA_W-1:1]}
                              : {shift_q[DATA_W-2:0], miso};
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign rx_data = rx_data_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign ss_n    = ((state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                      (state_q == ST_HOLD)) ? ~slave_en_q : {NUM_SS{1'b1}};

endmodule

// File: tb/tb_spi_master_engine.sv
// ---------------------------------------------------------------------------
// tb_spi_master_engine
//
// Bench for spi_master_engine. The bench observes the serial bus the way a
// slave would. It counts sclk edges relative to the latched cpol, collects the
// mosi bits at the slave's sample edges, and serves miso either as a loopback
// of mosi or from a slave word. The results are compared against values
// computed from the transfer rules: the received word, the busy length
// H*(2*W+2)+1, 32 leading and 32 trailing edges, and the ss_n pattern.
// ---------------------------------------------------------------------------
module tb_spi_master_engine;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic [W-1:0]  tx_data;
    logic          ctrl_cpol;
    logic          ctrl_cpha;
    logic          ctrl_order;
    logic [3:0]    ctrl_slave_en;
    logic          ctrl_rd;
    logic [1:0]    ctrl_scks;
    logic          start_op;
    logic          miso;
    logic          sclk;
    logic          mosi;
    logic [3:0]    ss_n;
    logic [W-1:0]  rx_data;
    logic          busy;
    logic          done;

    logic          loop_mode;
    logic          miso_slave;

    assign miso = loop_mode ? mosi : miso_slave;

    spi_master_engine #(.DATA_W(W), .NUM_SS(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_data       (tx_data),
        .ctrl_cpol     (ctrl_cpol),
        .ctrl_cpha     (ctrl_cpha),
        .ctrl_order    (ctrl_order),
        .ctrl_slave_en (ctrl_slave_en),
        .ctrl_rd       (ctrl_rd),
        .ctrl_scks     (ctrl_scks),
        .start_op      (start_op),
        .miso          (miso),
        .sclk          (sclk),
        .mosi          (mosi),
        .ss_n          (ss_n),
        .rx_data       (rx_data),
        .busy          (busy),
        .done          (done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vectors ----------------
    typedef struct {
        logic [W-1:0] tx;
        logic         cpol;
        logic         cpha;
        logic         order;
        logic [3:0]   en;
        logic         rd;
        logic [1:0]   scks;
        logic         loop;
        logic [W-1:0] sw;
        logic [W-1:0] exp_rx;
        int           exp_busy;
    } vec_t;

    function automatic vec_t mk(input logic [W-1:0] tx, input logic cpol,
                                input logic cpha, input logic order,
                                input logic [3:0] en, input logic rd,
                                input logic [1:0] scks, input logic loop,
                                input logic [W-1:0] sw, input logic [W-1:0] exp_rx,
                                input int exp_busy);
        vec_t v;
        v.tx = tx; v.cpol = cpol; v.cpha = cpha; v.order = order; v.en = en;
        v.rd = rd; v.scks = scks; v.loop = loop; v.sw = sw;
        v.exp_rx = exp_rx; v.exp_busy = exp_busy;
        return v;
    endfunction

    // ---------------- scoreboard state ----------------
    int           total;
    int           bad;
    logic [W-1:0] model_rx;

    int           busy_cnt;
    int           done_cnt;
    int           lead_cnt;
    int           trail_cnt;
    int           ss_bad;
    int           mosi_n;
    logic [W-1:0] mosi_word;
    logic         sclk_prev;
    logic         timed_out;
    logic         aborted;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Word bit carried by serial bit b.
    function automatic int bit_pos(input logic order, input int b);
        return order ? b : (W - 1 - b);
    endfunction

    // Drives one transfer with configuration v and watches the bus until busy
    // falls. mut_at >= 0 scrambles inputs and re-toggles start_op mid-run;
    // rst_at_lead >= 0 asserts reset once that many leading edges are seen.
    task automatic xfer(input vec_t v, input int mut_at, input int rst_at_lead);
        logic seen_busy;
        int   idx;
        @(posedge clk); #1;
        start_op      = 1'b0;
        tx_data       = v.tx;
        ctrl_cpol     = v.cpol;
        ctrl_cpha     = v.cpha;
        ctrl_order    = v.order;
        ctrl_slave_en = v.en;
        ctrl_rd       = v.rd;
        ctrl_scks     = v.scks;
        loop_mode     = v.loop;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_sclk", {63'd0, sclk}, {63'd0, v.cpol});
        busy_cnt = 0; done_cnt = 0; lead_cnt = 0; trail_cnt = 0; ss_bad = 0;
        mosi_n = 0; mosi_word = '0; sclk_prev = sclk; timed_out = 1'b0;
        aborted = 1'b0; seen_busy = 1'b0;
        miso_slave = v.sw[bit_pos(v.order, 0)];
        start_op = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (busy) begin
                seen_busy = 1'b1;
                busy_cnt++;
                if (done) done_cnt++;
                if (!done && (ss_n !== ~v.en)) ss_bad++;
                if (sclk !== sclk_prev) begin
                    if (sclk !== v.cpol) begin
                        if (!v.cpha && mosi_n < W) begin
                            mosi_word[bit_pos(v.order, mosi_n)] = mosi;
                            mosi_n++;
                        end
                        lead_cnt++;
                    end else begin
                        if (v.cpha && mosi_n < W) begin
                            mosi_word[bit_pos(v.order, mosi_n)] = mosi;
                            mosi_n++;
                        end
                        trail_cnt++;
                    end
                end
            end else if (ss_n !== 4'hF) begin
                ss_bad++;
            end
            sclk_prev = sclk;
            idx = v.cpha ? ((lead_cnt > 0) ? lead_cnt - 1 : 0) : trail_cnt;
            if (idx > W - 1) idx = W - 1;
            miso_slave = v.sw[bit_pos(v.order, idx)];
            if (mut_at >= 0 && busy_cnt == mut_at) begin
                start_op      = 1'b0;
                tx_data       = ~v.tx;
                ctrl_cpol     = ~v.cpol;
                ctrl_cpha     = ~v.cpha;
                ctrl_order    = ~v.order;
                ctrl_slave_en = ~v.en;
                ctrl_rd       = ~v.rd;
                ctrl_scks     = 2'd3;
            end
            if (mut_at >= 0 && busy_cnt == mut_at + 2) start_op = 1'b1;
            if (rst_at_lead >= 0 && lead_cnt == rst_at_lead) begin
                reset = 1'b0;
                #1;
                aborted = 1'b1;
                break;
            end
            if (seen_busy && !busy) break;
            if (cyc == 2999) timed_out = 1'b1;
        end
    endtask

    task automatic check_xfer(input string tag, input vec_t v, input logic [W-1:0] exp_rx,
                              input int exp_busy);
        chk({tag, "_timeout"}, {63'd0, timed_out}, 64'd0);
        chk({tag, "_busy_len"}, 64'(busy_cnt), 64'(exp_busy));
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_lead_edges"}, 64'(lead_cnt), 64'(W));
        chk({tag, "_trail_edges"}, 64'(trail_cnt), 64'(W));
        chk({tag, "_mosi_word"}, {32'd0, mosi_word}, {32'd0, v.tx});
        chk({tag, "_ss_n"}, 64'(ss_bad), 64'd0);
        chk({tag, "_rx_data"}, {32'd0, rx_data}, {32'd0, exp_rx});
    endtask

    task automatic watch_idle(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy) seen++;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    vec_t tbl[6];
    vec_t v;
    vec_t v4;
    logic [W-1:0] exp;

    initial begin
        total = 0; bad = 0; model_rx = '0;
        reset = 1'b0;
        start_op = 1'b1;
        tx_data = '0; ctrl_cpol = 1'b0; ctrl_cpha = 1'b0; ctrl_order = 1'b0;
        ctrl_slave_en = 4'h0; ctrl_rd = 1'b0; ctrl_scks = 2'd0;
        loop_mode = 1'b1; miso_slave = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", {63'd0, sclk}, 64'd0);
        chk("rst_mosi", {63'd0, mosi}, 64'd0);
        chk("rst_ss_n", {60'd0, ss_n}, 64'hF);
        chk("rst_rx_data", {32'd0, rx_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        // start_op already high at release must not start a transfer.
        reset = 1'b1;
        watch_idle("no_start_after_reset", 12);

        tbl[0] = mk(32'hA5A5_1234, 0, 0, 0, 4'b0001, 1, 2'd0, 1, 32'h0,         32'hA5A5_1234, 67);
        tbl[1] = mk(32'h0000_0001, 1, 1, 1, 4'b0001, 1, 2'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 265);
        tbl[2] = mk(32'h1234_5678, 0, 1, 0, 4'b0100, 1, 2'd1, 1, 32'h0,         32'h1234_5678, 133);
        tbl[3] = mk(32'hDEAD_BEEF, 0, 0, 0, 4'b0001, 0, 2'd0, 1, 32'h0,         32'h1234_5678, 67);
        tbl[4] = mk(32'h8000_0000, 1, 0, 0, 4'b1010, 1, 2'd0, 0, 32'h0,         32'h0000_0000, 67);
        tbl[5] = mk(32'h0F0F_3C3C, 0, 0, 1, 4'b0000, 1, 2'd3, 0, 32'hC3C3_0F0F, 32'hC3C3_0F0F, 529);

        for (int i = 0; i < 6; i++) begin
            xfer(tbl[i], -1, -1);
            check_xfer($sformatf("vec%0d", i), tbl[i], tbl[i].exp_rx, tbl[i].exp_busy);
            model_rx = tbl[i].exp_rx;
        end

        // Mid-transfer input changes and a start_op re-toggle are ignored.
        v4 = mk(32'h5A5A_00FF, 0, 0, 0, 4'b0010, 1, 2'd0, 1, 32'h0, 32'h5A5A_00FF, 67);
        xfer(v4, 10, -1);
        check_xfer("midchg", v4, v4.exp_rx, v4.exp_busy);
        model_rx = v4.exp_rx;
        watch_idle("midchg_no_restart", 30);

        // Randomized transfers against the rule-based model.
        for (int i = 0; i < 8; i++) begin
            v = mk($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom, 32'h0, 0);
            exp = v.rd ? (v.loop ? v.tx : v.sw) : model_rx;
            xfer(v, -1, -1);
            check_xfer($sformatf("rnd%0d", i), v, exp, (1 << v.scks) * (2 * W + 2) + 1);
            model_rx = exp;
        end

        // Reset in the middle of a transfer.
        xfer(tbl[0], -1, 16);
        chk("abort_reached", {63'd0, aborted}, 64'd1);
        chk("abort_ss_n", {60'd0, ss_n}, 64'hF);
        chk("abort_sclk", {63'd0, sclk}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_rx_data", {32'd0, rx_data}, 64'd0);
        model_rx = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        watch_idle("abort_no_start_high", 20);

        // A fresh edge after the abort runs normally.
        xfer(tbl[0], -1, -1);
        check_xfer("post_abort", tbl[0], tbl[0].exp_rx, tbl[0].exp_busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
